ppu_vram_port: RTL

//  CPU-facing VRAM access port for the PPU: implements the PPUADDR ($2006) two-write address latch
//  and PPUDATA ($2007) buffered read / write. It drives the 2 KiB CIRAM (11-bit addr, 1-cycle read)
//  as the initiating side, maps 14-bit PPU addresses through nametable mirroring and auto-increments.

---
 rtl/ppu_vram_port.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA port: two-write address latch, buffered VRAM reads, mirrored CIRAM access.
// Optional VRAM_MIRROR_SEL_EN adds a runtime mirror_vert input; otherwise mirroring is fixed by VMIR.
module ppu_vram_port #(
  parameter int unsigned AW   = 14,
  parameter int unsigned NW   = 11,
  parameter int unsigned DW   = 8,
  parameter bit          VMIR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_sel,
  input  logic [2:0]    cpu_reg,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          inc32,
  input  logic          w_clr,
  output logic          busy,
  output logic [AW-1:0] v_addr,
  output logic [NW-1:0] vram_addr,
  output logic          vram_we,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_rdata
`ifdef VRAM_MIRROR_SEL_EN
  ,
  input  logic          mirror_vert
`endif
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAP} state_t;

  localparam logic [AW-1:0] NT_LO = AW'('h2000);
  localparam logic [AW-1:0] NT_HI = AW'('h3EFF);

  state_t        state;
  logic [AW-1:0] v;
  logic [AW-1:0] t;
  logic          w;
  logic [DW-1:0] read_buf;
  logic          rd_hit;

  logic          mirror_v_c;
  logic          addr_wr_c;
  logic          data_acc_c;
  logic          w_eff_c;
  logic          in_nt_c;
  logic [NW-1:0] ciram_c;
  logic [AW-1:0] inc_c;

`ifdef VRAM_MIRROR_SEL_EN
  assign mirror_v_c = mirror_vert;
`else
  assign mirror_v_c = VMIR;
`endif

  // Request decode; anything arriving while busy is dropped.
  assign addr_wr_c  = cpu_sel & ~busy & cpu_we & (cpu_reg == 3'd6);
  assign data_acc_c = cpu_sel & ~busy & (cpu_reg == 3'd7);
  assign w_eff_c    = w & ~w_clr;
  assign in_nt_c    = (v >= NT_LO) && (v <= NT_HI);
  assign ciram_c    = NW'({(mirror_v_c ? v[10] : v[11]), v[9:0]});
  assign inc_c      = inc32 ? AW'(32) : AW'(1);

  assign v_addr = v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      v          <= '0;
      t          <= '0;
      w          <= 1'b0;
      read_buf   <= '0;
      rd_hit     <= 1'b0;
      cpu_rdata  <= '0;
      busy       <= 1'b0;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
    end else begin
      vram_we <= 1'b0;
      if (w_clr) w <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_wr_c) begin
            // A same-cycle PPUSTATUS read clears the toggle before this write uses it.
            if (!w_eff_c) begin
              t[AW-1:8] <= cpu_wdata[AW-9:0];
              w         <= 1'b1;
            end else begin
              t[7:0] <= cpu_wdata;
              v      <= {t[AW-1:8], cpu_wdata};
              w      <= 1'b0;
            end
          end else if (data_acc_c && cpu_we) begin
            vram_addr  <= ciram_c;
            vram_wdata <= cpu_wdata;
            vram_we    <= in_nt_c;
            busy       <= 1'b1;
            state      <= WR;
          end else if (data_acc_c) begin
            cpu_rdata <= read_buf;
            vram_addr <= ciram_c;
            rd_hit    <= in_nt_c;
            busy      <= 1'b1;
            state     <= RD_ISSUE;
          end
        end
        WR: begin
          v     <= v + inc_c;
          busy  <= 1'b0;
          state <= IDLE;
        end
        RD_ISSUE: begin
          v     <= v + inc_c;
          state <= RD_CAP;
        end
        RD_CAP: begin
          // CIRAM data for the address registered on accept is valid this cycle.
          read_buf <= rd_hit ? vram_rdata : '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
